// File: rtl/md5_batch_loader.sv
// Enumerates LEN-char lowercase candidates, writes one padded MD5 block per unit, then pulses start.
// First write one cycle after go; no backpressure: loads stall only in WAIT until the launched units report done.
module md5_batch_loader #(
    parameter int NUNITS = 32,
    parameter int LEN    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              stop,
    input  logic [NUNITS-1:0] done,
    output logic              write,
    output logic [8:0]        writeaddr,
    output logic [31:0]       writedata,
    output logic [NUNITS-1:0] start,
    output logic              busy,
    output logic              exhausted,
    output logic [31:0]       batch_count
);
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
    typedef logic [LEN-1:0][4:0] digits_t;

    localparam logic [4:0]        LAST_UNIT = 5'(NUNITS - 1);
    localparam logic [NUNITS-1:0] UNIT0_BIT = NUNITS'(1);

    state_t            state, state_n;
    digits_t           dig, dig_n, dig_inc;
    logic              inc_wrap;
    logic              wrap, wrap_n;
    logic              exhausted_n;
    logic [31:0]       batch_count_n;
    logic              stop_l, stop_l_n;
    logic [4:0]        unit, unit_n;
    logic [3:0]        word, word_n;
    logic [NUNITS-1:0] mask, mask_n;
    logic              guard, guard_n;
    logic              write_n;
    logic [8:0]        writeaddr_n;
    logic [31:0]       writedata_n;
    logic [NUNITS-1:0] start_n;

    // Little-endian MD5 block word: characters, 0x80 terminator, bit length in word 14.
    function automatic logic [31:0] msg_word(input digits_t d, input logic [3:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < LEN; i++) begin
            if (int'(w) == i / 4) r[8*(i%4) +: 8] = 8'h61 + {3'b000, d[i]};
        end
        if (int'(w) == LEN / 4) r[8*(LEN%4) +: 8] = 8'h80;
        if (w == 4'd14) r = 32'(LEN * 8);
        return r;
    endfunction

    always_comb begin
        logic carry;
        dig_inc = dig;
        carry   = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            if (carry) begin
                if (dig[i] == 5'd25) begin
                    dig_inc[i] = 5'd0;
                end else begin
                    dig_inc[i] = dig[i] + 5'd1;
                    carry      = 1'b0;
                end
            end
        end
        inc_wrap = carry;
    end

    always_comb begin
        state_n       = state;
        dig_n         = dig;
        wrap_n        = wrap;
        exhausted_n   = exhausted;
        batch_count_n = batch_count;
        stop_l_n      = stop_l;
        unit_n        = unit;
        word_n        = word;
        mask_n        = mask;
        guard_n       = 1'b0;
        write_n       = 1'b0;
        writeaddr_n   = writeaddr;
        writedata_n   = writedata;
        start_n       = '0;

        if (stop && state != IDLE) stop_l_n = 1'b1;

        case (state)
            IDLE: begin
                if (go) begin
                    dig_n         = '0;
                    wrap_n        = 1'b0;
                    exhausted_n   = 1'b0;
                    batch_count_n = '0;
                    stop_l_n      = 1'b0;
                    unit_n        = '0;
                    word_n        = '0;
                    mask_n        = '0;
                    write_n       = 1'b1;
                    writedata_n   = msg_word('0, 4'd0);
                    state_n       = LOAD;
                end
            end
            LOAD: begin
                if (word != 4'd15) begin
                    word_n      = word + 4'd1;
                    write_n     = 1'b1;
                    writedata_n = msg_word(dig, word + 4'd1);
                end else begin
                    mask_n = mask | (UNIT0_BIT << unit);
                    dig_n  = dig_inc;
                    if (inc_wrap) wrap_n = 1'b1;
                    // A wrapping increment ends the batch early so no unit sees a repeated candidate.
                    if (inc_wrap || unit == LAST_UNIT) begin
                        start_n       = mask_n;
                        batch_count_n = batch_count + 32'd1;
                        state_n       = START;
                    end else begin
                        unit_n      = unit + 5'd1;
                        word_n      = '0;
                        write_n     = 1'b1;
                        writedata_n = msg_word(dig_inc, 4'd0);
                    end
                end
            end
            START: begin
                guard_n = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                // Done bits seen during START and the guard cycle may be left over from the previous batch.
                if (!guard && (done & mask) == mask) begin
                    if (wrap) begin
                        exhausted_n = 1'b1;
                        state_n     = IDLE;
                    end else if (stop_l) begin
                        state_n = IDLE;
                    end else begin
                        mask_n      = '0;
                        unit_n      = '0;
                        word_n      = '0;
                        write_n     = 1'b1;
                        writedata_n = msg_word(dig, 4'd0);
                        state_n     = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (write_n) writeaddr_n = {unit_n, word_n};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dig         <= '0;
            wrap        <= 1'b0;
            exhausted   <= 1'b0;
            batch_count <= '0;
            stop_l      <= 1'b0;
            unit        <= '0;
            word        <= '0;
            mask        <= '0;
            guard       <= 1'b0;
            write       <= 1'b0;
            writeaddr   <= '0;
            writedata   <= '0;
            start       <= '0;
        end else begin
            state       <= state_n;
            dig         <= dig_n;
            wrap        <= wrap_n;
            exhausted   <= exhausted_n;
            batch_count <= batch_count_n;
            stop_l      <= stop_l_n;
            unit        <= unit_n;
            word        <= word_n;
            mask        <= mask_n;
            guard       <= guard_n;
            write       <= write_n;
            writeaddr   <= writeaddr_n;
            writedata   <= writedata_n;
            start       <= start_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_md5_batch_loader.sv
// Directed bench for md5_batch_loader: three instances (2x4, 32x1, 2x8) checked against a write scoreboard.
module tb_md5_batch_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, go_a, stop_a, go_b, go_c, stop_0;
    logic [1:0]  done_a, done_c;
    logic [31:0] done_b;

    logic        write_a, write_b, write_c;
    logic [8:0]  waddr_a, waddr_b, waddr_c;
    logic [31:0] wdata_a, wdata_b, wdata_c;
    logic [1:0]  start_a, start_c;
    logic [31:0] start_b;
    logic        busy_a, busy_b, busy_c, exh_a, exh_b, exh_c;
    logic [31:0] bc_a, bc_b, bc_c;

    md5_batch_loader #(.NUNITS(2), .LEN(4)) dut_a (
        .clk(clk), .reset(reset), .go(go_a), .stop(stop_a), .done(done_a),
        .write(write_a), .writeaddr(waddr_a), .writedata(wdata_a), .start(start_a),
        .busy(busy_a), .exhausted(exh_a), .batch_count(bc_a));

    md5_batch_loader #(.NUNITS(32), .LEN(1)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .stop(stop_0), .done(done_b),
        .write(write_b), .writeaddr(waddr_b), .writedata(wdata_b), .start(start_b),
        .busy(busy_b), .exhausted(exh_b), .batch_count(bc_b));

    md5_batch_loader #(.NUNITS(2), .LEN(8)) dut_c (
        .clk(clk), .reset(reset), .go(go_c), .stop(stop_0), .done(done_c),
        .write(write_c), .writeaddr(waddr_c), .writedata(wdata_c), .start(start_c),
        .busy(busy_c), .exhausted(exh_c), .batch_count(bc_c));

    int          sel;
    logic        mw;
    logic [8:0]  ma;
    logic [31:0] md;
    always_comb begin
        case (sel)
            0:       begin mw = write_a; ma = waddr_a; md = wdata_a; end
            1:       begin mw = write_b; ma = waddr_b; md = wdata_b; end
            default: begin mw = write_c; ma = waddr_c; md = wdata_c; end
        endcase
    end

    int nerr = 0;
    int nchk = 0;
    logic [40:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference block built byte by byte; candidate index is base 26 with digit 0 least significant.
    function automatic logic [31:0] model_word(input int len, input int cand, input int w);
        logic [7:0] blk [64];
        int c;
        c = cand;
        for (int k = 0; k < 64; k++) blk[k] = 8'h00;
        for (int k = 0; k < len; k++) begin
            blk[k] = 8'(32'h61 + c % 26);
            c = c / 26;
        end
        blk[len] = 8'h80;
        blk[56]  = 8'(len * 8);
        return {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
    endfunction

    task automatic push_batch(input int len, input int first, input int units);
        for (int u = 0; u < units; u++)
            for (int w = 0; w < 16; w++)
                sb.push_back({5'(u), 4'(w), model_word(len, first + u, w)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_writes(input int n, input int stop_at);
        logic [40:0] e;
        for (int i = 0; i < n; i++) begin
            stop_a = (i == stop_at);
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : 41'bx;
            check("write_strobe", 64'(mw), 64'(1));
            check("write_addr_data", 64'({ma, md}), 64'(e));
            tick();
        end
        stop_a = 1'b0;
    endtask

    initial begin
        int wcnt;
        reset = 1'b1; go_a = 1'b0; stop_a = 1'b0; go_b = 1'b0; go_c = 1'b0; stop_0 = 1'b0;
        done_a = 2'b11; done_b = '1; done_c = 2'b00; sel = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_write", 64'(write_a), 64'(0));
        check("rst_writeaddr", 64'(waddr_a), 64'(0));
        check("rst_writedata", 64'(wdata_a), 64'(0));
        check("rst_start", 64'(start_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_exhausted", 64'(exh_a), 64'(0));
        check("rst_batch_count", 64'(bc_a), 64'(0));
        tick();
        reset = 1'b0;

        // Basic batch: go in cycle 0, writes in cycles 1..32, start in 33.
        go_a = 1'b1;
        push_batch(4, 0, 2);
        tick();
        go_a = 1'b0;
        expect_writes(32, -1);
        @(negedge clk);
        check("start_mask", 64'(start_a), 64'(2'b11));
        check("start_no_write", 64'(write_a), 64'(0));
        check("batch_count_1", 64'(bc_a), 64'(1));
        push_batch(4, 2, 2);
        tick();
        @(negedge clk);
        check("start_one_cycle", 64'(start_a), 64'(0));
        check("guard_no_exit", 64'(write_a), 64'(0));
        check("busy_in_wait", 64'(busy_a), 64'(1));
        tick();
        @(negedge clk);
        check("exit_sample_no_write", 64'(write_a), 64'(0));
        tick();
        expect_writes(6, -1);

        // Reset while the 7th write of the second batch is on the bus.
        reset = 1'b1;
        expect_writes(1, -1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_write", 64'(write_a), 64'(0));
        check("rst_mid_start", 64'(start_a), 64'(0));
        check("rst_mid_busy", 64'(busy_a), 64'(0));
        check("rst_mid_writeaddr", 64'(waddr_a), 64'(0));
        check("rst_mid_batch_count", 64'(bc_a), 64'(0));
        sb.delete();

        // Restart from "aaaa", with stop pulsed mid-LOAD.
        tick();
        go_a = 1'b1;
        push_batch(4, 0, 2);
        tick();
        go_a = 1'b0;
        expect_writes(32, 4);
        @(negedge clk);
        check("stop_start_mask", 64'(start_a), 64'(2'b11));
        check("stop_batch_count", 64'(bc_a), 64'(1));
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (write_a) wcnt++;
        end
        check("stop_no_more_writes", 64'(wcnt), 64'(0));
        check("stop_idle", 64'(busy_a), 64'(0));
        check("stop_batch_count_final", 64'(bc_a), 64'(1));
        check("stop_not_exhausted", 64'(exh_a), 64'(0));

        // Exhaustion: LEN=1 wraps after 26 units.
        sel = 1;
        tick();
        go_b = 1'b1;
        push_batch(1, 0, 26);
        tick();
        go_b = 1'b0;
        expect_writes(416, -1);
        @(negedge clk);
        check("exh_start_mask", 64'(start_b), 64'(32'h03FF_FFFF));
        check("exh_batch_count", 64'(bc_b), 64'(1));
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (write_b) wcnt++;
        end
        check("exh_no_more_writes", 64'(wcnt), 64'(0));
        check("exh_busy", 64'(busy_b), 64'(0));
        check("exh_flag", 64'(exh_b), 64'(1));

        // Length 8 padding.
        sel = 2;
        tick();
        go_c = 1'b1;
        push_batch(8, 0, 2);
        tick();
        go_c = 1'b0;
        expect_writes(32, -1);
        @(negedge clk);
        check("len8_start_mask", 64'(start_c), 64'(2'b11));
        check("len8_batch_count", 64'(bc_c), 64'(1));
        check("len8_busy", 64'(busy_c), 64'(1));
        check("len8_not_exhausted", 64'(exh_c), 64'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
